// File: rtl/femto_bus_pkg.sv
// Shared definitions for the FemtoRV32 bus fabric: FSM encoding, read-return
// source, default slave address map and helper width functions.
package femto_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } fsm_state_t;

  // Where mem_rdata comes from for the most recent read.
  typedef enum logic [1:0] {
    RSRC_SLAVE   = 2'd0,
    RSRC_TIMEOUT = 2'd1,
    RSRC_ZERO    = 2'd2
  } rd_src_t;

  localparam logic [15:0] MAP_FLASH  = 16'h0000;
  localparam logic [15:0] MAP_SPIRAM = 16'h0001;
  localparam logic [15:0] MAP_UART   = 16'h0040;

  // Slave 0 is lowest; slave i lives in bits [i*16 +: 16].
  localparam logic [63:0] DEFAULT_BASE_MAP = {MAP_SPIRAM, MAP_UART, MAP_FLASH, MAP_FLASH};

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Watchdog counter width, clamped to 8..32 bits.
  function automatic int wdog_width(input int tc);
    int w;
    w = $clog2(tc + 1);
    if (w < 8) w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/femto_bus_decoder.sv
// Combinational address-to-channel priority decoder. The lowest matching map
// entry wins; no match returns DEFAULT_SLAVE with hit = 0.
module femto_bus_decoder
  import femto_bus_pkg::*;
#(
  parameter int                          NUM_SLAVES    = 4,
  parameter int                          SEL_W         = 16,
  parameter logic [NUM_SLAVES*SEL_W-1:0] BASE_MAP      = DEFAULT_BASE_MAP,
  parameter int                          DEFAULT_SLAVE = 0,
  parameter int                          IDX_W         = idx_width(NUM_SLAVES)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  logic [NUM_SLAVES-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = (sel == BASE_MAP[gi*SEL_W +: SEL_W]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    idx = IDX_W'(DEFAULT_SLAVE);
    hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/femto_bus_fabric.sv
// Memory-mapped interconnect between the FemtoRV32 memory port and
// NUM_SLAVES slave channels. Tracks the owning slave per transaction,
// latches the read-return channel, runs a busy watchdog and keeps a sticky
// first-error capture register.
// Optional build macro: FEMTO_FABRIC_UNMAPPED_ERR_EN -- unmapped accesses are
// not forwarded, reads return zero, and the access is logged as an error.
// Without it, unmapped accesses go to DEFAULT_SLAVE and are not logged.
module femto_bus_fabric
  import femto_bus_pkg::*;
#(
  parameter int                                          NUM_SLAVES     = 4,
  parameter int                                          SEL_HI         = 31,
  parameter int                                          SEL_LO         = 16,
  parameter logic [NUM_SLAVES*(SEL_HI-SEL_LO+1)-1:0]     BASE_MAP       = DEFAULT_BASE_MAP,
  parameter int                                          DEFAULT_SLAVE  = 0,
  parameter int                                          TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                                 TIMEOUT_DATA   = DEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wmask,
  input  logic                     mem_rstrb,
  output logic [31:0]              mem_rdata,
  output logic                     mem_rbusy,
  output logic                     mem_wbusy,
  output logic [NUM_SLAVES-1:0]    s_rd,
  output logic [NUM_SLAVES-1:0]    s_wr,
  input  logic [NUM_SLAVES*32-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_rbusy,
  input  logic [NUM_SLAVES-1:0]    s_wbusy,
  input  logic                     err_clr,
  output logic                     err_valid,
  output logic [31:0]              err_addr,
  output logic                     err_timeout
);

  localparam int              SEL_W   = SEL_HI - SEL_LO + 1;
  localparam int              IDX_W   = idx_width(NUM_SLAVES);
  localparam int              CNT_W   = wdog_width(TIMEOUT_CYCLES);
  localparam bit              WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

  fsm_state_t       state_reg, state_next;
  logic [IDX_W-1:0] pend_idx_reg, pend_idx_next;
  logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
  rd_src_t          rd_src_reg, rd_src_next;
  logic [31:0]      pend_addr_reg, pend_addr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_valid_reg, err_timeout_reg;
  logic [31:0]      err_addr_reg;

  logic [IDX_W-1:0] dec_idx;
  logic             hit;
  logic             route_ok, unmapped_evt, unm_rd;
  logic             wr_req, waiting, to_hit;
  logic             rd_done, wr_done, free, start_rd, start_wr;
  logic [31:0]      rdata_arr [NUM_SLAVES];

  // Write data goes to the slaves straight from the CPU bus, not through here.
  logic [31:0] unused_wdata;
  assign unused_wdata = mem_wdata;

  femto_bus_decoder #(
    .NUM_SLAVES    (NUM_SLAVES),
    .SEL_W         (SEL_W),
    .BASE_MAP      (BASE_MAP),
    .DEFAULT_SLAVE (DEFAULT_SLAVE),
    .IDX_W         (IDX_W)
  ) u_decoder (
    .sel (mem_addr[SEL_HI:SEL_LO]),
    .idx (dec_idx),
    .hit (hit)
  );

  assign wr_req  = |mem_wmask;
  assign waiting = (state_reg != ST_IDLE);
  assign to_hit  = WDOG_EN && waiting && (cnt_reg == TO_VAL);
  assign rd_done = (state_reg == ST_RD_WAIT) && (!s_rbusy[pend_idx_reg] || to_hit);
  assign wr_done = (state_reg == ST_WR_WAIT) && (!s_wbusy[pend_idx_reg] || to_hit);
  assign free    = (state_reg == ST_IDLE) || rd_done || wr_done;

`ifdef FEMTO_FABRIC_UNMAPPED_ERR_EN
  assign route_ok     = hit;
  assign unm_rd       = free && mem_rstrb && !hit;
  assign unmapped_evt = free && (mem_rstrb || wr_req) && !hit;
`else
  logic unused_hit;
  assign unused_hit   = hit;
  assign route_ok     = 1'b1;
  assign unm_rd       = 1'b0;
  assign unmapped_evt = 1'b0;
`endif

  assign start_rd = free && mem_rstrb && route_ok;
  assign start_wr = free && wr_req && !mem_rstrb && route_ok && s_wbusy[dec_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_chan
      assign s_rd[gi]      = mem_rstrb && route_ok && (dec_idx == IDX_W'(gi));
      assign s_wr[gi]      = wr_req && route_ok && (dec_idx == IDX_W'(gi));
      assign rdata_arr[gi] = s_rdata[gi*32 +: 32];
    end
  endgenerate

  // Only the owning slave's busy line is honoured; a watchdog hit forces it low.
  assign mem_rbusy = (state_reg == ST_RD_WAIT) && s_rbusy[pend_idx_reg] && !to_hit;

  // Write busy: combinational pass-through while idle, owner's line while waiting.
  always_comb begin
    mem_wbusy = 1'b0;
    case (state_reg)
      ST_IDLE:    mem_wbusy = wr_req && route_ok && s_wbusy[dec_idx];
      ST_WR_WAIT: mem_wbusy = s_wbusy[pend_idx_reg] && !to_hit;
      default:    mem_wbusy = 1'b0;
    endcase
  end

  // Read return: timeout data on the timing-out cycle and after, zero for
  // dropped unmapped reads, otherwise the latched read channel.
  always_comb begin
    mem_rdata = rdata_arr[rd_idx_reg];
    if ((state_reg == ST_RD_WAIT) && to_hit) begin
      mem_rdata = TIMEOUT_DATA;
    end else begin
      case (rd_src_reg)
        RSRC_TIMEOUT: mem_rdata = TIMEOUT_DATA;
        RSRC_ZERO:    mem_rdata = 32'h0000_0000;
        default:      mem_rdata = rdata_arr[rd_idx_reg];
      endcase
    end
  end

  // Next-state logic: completion returns to idle, a new start overrides it.
  always_comb begin
    state_next     = state_reg;
    pend_idx_next  = pend_idx_reg;
    pend_addr_next = pend_addr_reg;
    rd_idx_next    = rd_idx_reg;
    rd_src_next    = rd_src_reg;
    cnt_next       = waiting ? (cnt_reg + 1'b1) : '0;
    if (rd_done || wr_done) state_next = ST_IDLE;
    if (rd_done && to_hit) rd_src_next = RSRC_TIMEOUT;
    if (start_rd) begin
      state_next     = ST_RD_WAIT;
      pend_idx_next  = dec_idx;
      rd_idx_next    = dec_idx;
      pend_addr_next = mem_addr;
      rd_src_next    = RSRC_SLAVE;
      cnt_next       = '0;
    end else if (start_wr) begin
      state_next     = ST_WR_WAIT;
      pend_idx_next  = dec_idx;
      pend_addr_next = mem_addr;
      cnt_next       = '0;
    end else if (unm_rd) begin
      rd_src_next    = RSRC_ZERO;
    end
  end

  // Transaction state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      pend_idx_reg  <= IDX_W'(DEFAULT_SLAVE);
      rd_idx_reg    <= IDX_W'(DEFAULT_SLAVE);
      rd_src_reg    <= RSRC_SLAVE;
      pend_addr_reg <= 32'h0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pend_idx_reg  <= pend_idx_next;
      rd_idx_reg    <= rd_idx_next;
      rd_src_reg    <= rd_src_next;
      pend_addr_reg <= pend_addr_next;
      cnt_reg       <= cnt_next;
    end
  end

  // Sticky first-error capture; clear wins over a simultaneous new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_reg   <= 1'b0;
      err_addr_reg    <= 32'h0;
      err_timeout_reg <= 1'b0;
    end else if (err_clr) begin
      err_valid_reg   <= 1'b0;
      err_addr_reg    <= 32'h0;
      err_timeout_reg <= 1'b0;
    end else if (!err_valid_reg) begin
      if (to_hit) begin
        err_valid_reg   <= 1'b1;
        err_addr_reg    <= pend_addr_reg;
        err_timeout_reg <= 1'b1;
      end else if (unmapped_evt) begin
        err_valid_reg   <= 1'b1;
        err_addr_reg    <= mem_addr;
        err_timeout_reg <= 1'b0;
      end
    end
  end

  assign err_valid   = err_valid_reg;
  assign err_addr    = err_addr_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_femto_bus_fabric.sv
// Scoreboard bench for femto_bus_fabric. Stimulus pushes the expected
// response of each transaction; a monitor pops it when the CPU side issues
// the access and follows the transaction to completion.
module tb_femto_bus_fabric;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  mem_addr = 32'h0;
  logic [31:0]  mem_wdata = 32'h1234_5678;
  logic [3:0]   mem_wmask = 4'h0;
  logic         mem_rstrb = 1'b0;
  logic [31:0]  mem_rdata;
  logic         mem_rbusy, mem_wbusy;
  logic [3:0]   s_rd, s_wr;
  logic [127:0] s_rdata = {32'h3333_0003, 32'h0000_0041, 32'h2222_0001, 32'h1111_0000};
  logic [3:0]   s_rbusy = 4'h0;
  logic [3:0]   s_wbusy = 4'h0;
  logic         err_clr = 1'b0;
  logic         err_valid, err_timeout;
  logic [31:0]  err_addr;

  always #5 clk = ~clk;

  femto_bus_fabric #(
    .NUM_SLAVES     (4),
    .SEL_HI         (31),
    .SEL_LO         (16),
    .BASE_MAP       (64'h0001_0040_0002_0000),
    .DEFAULT_SLAVE  (0),
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rstrb   (mem_rstrb),
    .mem_rdata   (mem_rdata),
    .mem_rbusy   (mem_rbusy),
    .mem_wbusy   (mem_wbusy),
    .s_rd        (s_rd),
    .s_wr        (s_wr),
    .s_rdata     (s_rdata),
    .s_rbusy     (s_rbusy),
    .s_wbusy     (s_wbusy),
    .err_clr     (err_clr),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_timeout (err_timeout)
  );

  typedef struct packed {
    bit          is_wr;
    bit          abort;
    logic [3:0]  sel;
    int          busy;
    logic [31:0] rdata;
    logic        ev;
    logic        et;
    logic [31:0] ea;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    mon_phase = 0;
  exp_t  cur;
  string cur_name;
  int    busy_seen;
  int    guard;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  task automatic expect_tx(input string nm, input bit wr, input bit ab, input logic [3:0] sel,
                           input int busy, input logic [31:0] rd,
                           input logic ev, input logic et, input logic [31:0] ea);
    exp_t e;
    e.is_wr = wr; e.abort = ab; e.sel = sel; e.busy = busy; e.rdata = rd;
    e.ev = ev; e.et = et; e.ea = ea;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: picks up each access at issue, follows busy, checks completion.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (mon_phase == 1 && cur.abort) begin
        chk({cur_name, "_rbusy_rst"}, {31'b0, mem_rbusy}, 32'h0);
        chk({cur_name, "_errv_rst"}, {31'b0, err_valid}, 32'h0);
        $display("tx %s: aborted by reset after %0d busy cycles", cur_name, busy_seen);
      end else if (mon_phase != 0) begin
        fail_now({cur_name, "_unexpected_reset"});
      end
      mon_phase = 0;
    end else begin
      case (mon_phase)
        0: if (mem_rstrb || mem_wmask != 4'h0) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_access");
          end else begin
            cur = exp_q.pop_front();
            cur_name = name_q.pop_front();
            guard = 0;
            if (cur.is_wr) begin
              chk({cur_name, "_s_wr"}, {28'b0, s_wr}, {28'b0, cur.sel});
              busy_seen = mem_wbusy ? 1 : 0;
              mon_phase = mem_wbusy ? 2 : 3;
            end else begin
              chk({cur_name, "_s_rd"}, {28'b0, s_rd}, {28'b0, cur.sel});
              busy_seen = 0;
              mon_phase = 1;
            end
          end
        end
        1: begin
          if (mem_rbusy) begin
            busy_seen++;
            guard++;
            if (guard > 60) begin
              fail_now({cur_name, "_rbusy_stuck"});
              mon_phase = 0;
            end
          end else if (cur.abort) begin
            fail_now({cur_name, "_completed_before_reset"});
            mon_phase = 0;
          end else begin
            chk({cur_name, "_rdata"}, mem_rdata, cur.rdata);
            mon_phase = 3;
          end
        end
        2: begin
          if (mem_wbusy) begin
            busy_seen++;
            guard++;
            if (guard > 60) begin
              fail_now({cur_name, "_wbusy_stuck"});
              mon_phase = 0;
            end
          end else begin
            mon_phase = 3;
          end
        end
        default: begin
          chk({cur_name, "_busy_cycles"}, busy_seen, cur.busy);
          if (!cur.is_wr) chk({cur_name, "_rdata_hold"}, mem_rdata, cur.rdata);
          chk({cur_name, "_err_valid"}, {31'b0, err_valid}, {31'b0, cur.ev});
          chk({cur_name, "_err_timeout"}, {31'b0, err_timeout}, {31'b0, cur.et});
          chk({cur_name, "_err_addr"}, err_addr, cur.ea);
          $display("tx %s: busy=%0d rdata=%h err=%b/%b/%h", cur_name, busy_seen,
                   mem_rdata, err_valid, err_timeout, err_addr);
          mon_phase = 0;
        end
      endcase
    end
  end

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && mon_phase == 0) break;
    end
    if (k == 100) fail_now("wait_done_timeout");
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input int slave, input int lat);
    mem_addr = addr;
    mem_rstrb = 1'b1;
    @(posedge clk); #1;
    mem_rstrb = 1'b0;
    mem_addr = 32'h0001_0000;   // address moves on; read data must not follow it
    if (lat > 0) begin
      s_rbusy[slave] = 1'b1;
      repeat (lat) @(posedge clk);
      #1;
      s_rbusy[slave] = 1'b0;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int slave, input int lat);
    mem_addr = addr;
    mem_wmask = 4'hF;
    if (lat > 0) s_wbusy[slave] = 1'b1;
    @(posedge clk); #1;
    mem_wmask = 4'h0;
    if (lat > 0) begin
      repeat (lat - 1) @(posedge clk);
      #1;
      s_wbusy[slave] = 1'b0;
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr_valid", {31'b0, err_valid}, 32'h0);
    chk("err_clr_timeout", {31'b0, err_timeout}, 32'h0);
    chk("err_clr_addr", err_addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rbusy", {31'b0, mem_rbusy}, 32'h0);
    chk("rst_wbusy", {31'b0, mem_wbusy}, 32'h0);
    chk("rst_err_valid", {31'b0, err_valid}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_timeout", {31'b0, err_timeout}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Slave 2 read, 3 busy cycles.
    expect_tx("rd_s2", 0, 0, 4'b0100, 3, 32'h0000_0041, 0, 0, 32'h0);
    do_read(32'h0040_0004, 2, 3);
    wait_done();

    // Slave 1 read while slave 0 is permanently busy.
    s_rbusy[0] = 1'b1;
    expect_tx("rd_s1_ign0", 0, 0, 4'b0010, 2, 32'h2222_0001, 0, 0, 32'h0);
    do_read(32'h0002_0000, 1, 2);
    wait_done();
    s_rbusy[0] = 1'b0;

    // Writes: slave 3 busy for 2 cycles, slave 0 immediate.
    expect_tx("wr_s3", 1, 0, 4'b1000, 2, 32'h0, 0, 0, 32'h0);
    do_write(32'h0001_0008, 3, 2);
    wait_done();
    expect_tx("wr_s0", 1, 0, 4'b0001, 0, 32'h0, 0, 0, 32'h0);
    do_write(32'h0000_0100, 0, 0);
    wait_done();

    // Unmapped read.
`ifdef FEMTO_FABRIC_UNMAPPED_ERR_EN
    expect_tx("rd_unmapped", 0, 0, 4'b0000, 0, 32'h0000_0000, 1, 0, 32'h0099_0000);
    do_read(32'h0099_0000, 0, 0);
    wait_done();
    clear_err();
`else
    expect_tx("rd_unmapped", 0, 0, 4'b0001, 0, 32'h1111_0000, 0, 0, 32'h0);
    do_read(32'h0099_0000, 0, 0);
    wait_done();
`endif

    // Watchdog: slave 0 stuck busy, then a second timeout must not overwrite.
    s_rbusy[0] = 1'b1;
    expect_tx("rd_timeout", 0, 0, 4'b0001, 4, 32'hDEAD_BEEF, 1, 1, 32'h0000_0010);
    do_read(32'h0000_0010, 0, 0);
    wait_done();
    expect_tx("rd_timeout2", 0, 0, 4'b0001, 4, 32'hDEAD_BEEF, 1, 1, 32'h0000_0010);
    do_read(32'h0000_0020, 0, 0);
    wait_done();
    s_rbusy[0] = 1'b0;
    clear_err();

    // Reset during RD_WAIT abandons the read.
    s_rbusy[2] = 1'b1;
    expect_tx("rd_reset", 0, 1, 4'b0100, 0, 32'h0, 0, 0, 32'h0);
    mem_addr = 32'h0040_0000;
    mem_rstrb = 1'b1;
    @(posedge clk); #1;
    mem_rstrb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_rbusy[2] = 1'b0;
    wait_done();

    expect_tx("rd_after_rst", 0, 0, 4'b0100, 1, 32'h0000_0041, 0, 0, 32'h0);
    do_read(32'h0040_0004, 2, 1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
